// File: rtl/ex_204_demux_router_pkg.sv
// Shared constants and destination decode for the 6-channel demux router.
package ex_204_pkg;
  localparam int NCH = 6;

  localparam logic [2:0] CH_A = 3'd0;
  localparam logic [2:0] CH_B = 3'd1;
  localparam logic [2:0] CH_C = 3'd2;
  localparam logic [2:0] CH_D = 3'd3;
  localparam logic [2:0] CH_E = 3'd4;
  localparam logic [2:0] CH_F = 3'd5;

  // Same priority tree as the 6-source mux, used here to pick a destination.
  function automatic logic [2:0] dest_of(input logic s1, s2, s3, s4, s5);
    if (s1)           return CH_A;
    else if (s2 & s3) return CH_B;
    else if (s2)      return CH_C;
    else if (s4)      return CH_D;
    else if (s5)      return CH_E;
    else              return CH_F;
  endfunction
endpackage

// File: rtl/ex_204_demux_router_if.sv
// Producer/consumer bus of the demux router: one input stream, six output channels.
interface ex_204_if #(parameter int DW = 4);
  import ex_204_pkg::*;

  logic [DW-1:0]     in_data;
  logic              in_valid;
  logic              in_ready;
  logic              sel1, sel2, sel3, sel4, sel5;
  logic [NCH*DW-1:0] out_data;
  logic [NCH-1:0]    out_valid;
  logic [NCH-1:0]    out_ready;

  modport slave (
    input  in_data, in_valid, sel1, sel2, sel3, sel4, sel5, out_ready,
    output in_ready, out_data, out_valid
  );

  modport master (
    output in_data, in_valid, sel1, sel2, sel3, sel4, sel5, out_ready,
    input  in_ready, out_data, out_valid
  );
endinterface

// File: rtl/ex_204_demux_router_chan_buf.sv
// One-entry valid/ready channel buffer; delivery counter present under EX_204_COUNT_EN.
module ex_204_chan_buf #(
  parameter int DW = 4,
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic [DW-1:0] load_data,
  input  logic          rdy,
  input  logic          flush,
  output logic          valid,
  output logic [DW-1:0] data,
  output logic [CW-1:0] cnt
);
  logic drain;
  // A consumer handshake during flush is not a delivery.
  assign drain = valid & rdy & ~flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      data  <= '0;
    end else if (flush) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      data  <= load_data;
    end else if (drain) begin
      valid <= 1'b0;
    end
  end

`ifdef EX_204_COUNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 cnt <= '0;
    else if (drain && cnt != '1) cnt <= cnt + 1'b1;
  end
`else
  assign cnt = '0;
`endif
endmodule

// File: rtl/ex_204_demux_router.sv
// Steers one input stream into six buffered channels by sel priority.
// Optional per-channel delivery counters: define EX_204_COUNT_EN.
module ex_204_demux_router
  import ex_204_pkg::*;
#(
  parameter int DW = 4,
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  ex_204_if.slave       bus,
  input  logic          flush,
  input  logic [2:0]    cnt_sel,
  output logic [CW-1:0] cnt_out
);
  logic [2:0]                dest;
  logic [NCH-1:0]            load;
  logic [NCH-1:0][DW-1:0]    data;
  logic [NCH-1:0][CW-1:0]    cnt;

  assign dest = dest_of(bus.sel1, bus.sel2, bus.sel3, bus.sel4, bus.sel5);

  // Only the addressed channel gates acceptance, so a stalled channel blocks nobody else.
  assign bus.in_ready = rst_n & ~flush & (~bus.out_valid[dest] | bus.out_ready[dest]);
  assign bus.out_data = data;

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    assign load[g] = bus.in_valid & bus.in_ready & (dest == 3'(g));

    ex_204_chan_buf #(.DW(DW), .CW(CW)) u_buf (
      .clk       (clk),
      .rst_n     (rst_n),
      .load      (load[g]),
      .load_data (bus.in_data),
      .rdy       (bus.out_ready[g]),
      .flush     (flush),
      .valid     (bus.out_valid[g]),
      .data      (data[g]),
      .cnt       (cnt[g])
    );
  end

`ifdef EX_204_COUNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                    cnt_out <= '0;
    else if (cnt_sel < 3'(NCH))    cnt_out <= cnt[cnt_sel];
    else                           cnt_out <= '0;
  end
`else
  logic unused_cnt;
  assign unused_cnt = ^{cnt_sel, cnt};
  assign cnt_out    = '0;
`endif
endmodule
